vendo_param: RTL and testbench

- Parametrised next-generation vending controller with N selectable items and a per-item price table.
- Accumulates 1- and 5-unit coins into a credit register and dispenses one item per accepted selection.
- Returns leftover credit as serial 1-unit change pulses; supports cancel/refund and coin rejection at credit saturation.
- Replaces the separate divider + fixed two-item FSM pair: the divider is now an internal clock-enable, so the whole block runs on the board clock.

---
 rtl/vendo_param.sv | 153 +++++++++++++++
 tb/tb_vendo_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vendo_param.sv
// Parametrised vending controller: coin credit, per-item price table, serial change.
// Everything runs on the board clock and advances on an internal divided clock-enable.
//
// state      | meaning
// -----------|---------------------------------------------------------------
// S_IDLE     | no credit held, waiting for coins (or a price-0 selection)
// S_COLLECT  | credit > 0, accepting coins, selection or cancel
// S_DISPENSE | disp one-hot pulse for one tick, then change or idle
// S_CHANGE   | alternating high/low change phases until credit reaches 0
module vendo_param #(
    parameter int                           N_ITEMS    = 4,
    parameter int                           PRICE_W    = 4,
    parameter int                           CREDIT_W   = 5,
    parameter logic [N_ITEMS*PRICE_W-1:0]   PRICE_LIST = {4'd9, 4'd7, 4'd6, 4'd5},
    parameter int                           DIV_COUNT  = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N_ITEMS-1:0]  sel,
    input  logic                p_1,
    input  logic                p_5,
    input  logic                cancel,
    output logic [N_ITEMS-1:0]  disp,
    output logic                change,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                tick_out
);

    localparam int CW1   = CREDIT_W + 1;
    localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW1-1:0]      CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] ONE        = CREDIT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DIV_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

    logic [CNT_W-1:0]    r_div_cnt;
    logic                w_tick;
    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [N_ITEMS-1:0]  r_disp, w_disp_nxt;
    logic                r_change, w_change_nxt;
    logic                r_rej, w_rej_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_coin;
    logic                w_sel_ok;
    logic [CW1-1:0]      w_coin_val;
    logic [CW1-1:0]      w_sum;
    logic [CREDIT_W-1:0] w_price;

    assign w_tick = (r_div_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    assign w_coin     = p_1 | p_5;
    assign w_sel_ok   = $onehot(sel);
    assign w_coin_val = CW1'(p_1) + (p_5 ? CW1'(5) : CW1'(0));
    assign w_sum      = {1'b0, r_credit} + w_coin_val;

    // sel is one-hot whenever the price is used, so OR-ing the entries selects one
    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) w_price = w_price | CREDIT_W'(PRICE_LIST[i*PRICE_W +: PRICE_W]);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_disp_nxt   = '0;
        w_change_nxt = 1'b0;
        w_rej_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                if (cancel && (r_credit != '0)) begin
                    w_state_nxt  = S_CHANGE;
                    w_change_nxt = 1'b1;
                    w_credit_nxt = r_credit - ONE;
                end else if (w_coin) begin
                    if (w_sum <= CREDIT_MAX) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_state_nxt  = S_COLLECT;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end else if (w_sel_ok && (r_credit >= w_price)) begin
                    w_credit_nxt = r_credit - w_price;
                    w_disp_nxt   = sel;
                    w_state_nxt  = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                w_rej_nxt = w_coin;
                if (r_credit != '0) begin
                    w_state_nxt  = S_CHANGE;
                    w_change_nxt = 1'b1;
                    w_credit_nxt = r_credit - ONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHANGE: begin
                // r_change doubles as the phase bit: high phase just emitted -> low phase now
                w_rej_nxt = w_coin;
                if (r_change) begin
                    if (r_credit == '0) w_state_nxt = S_IDLE;
                end else begin
                    w_change_nxt = 1'b1;
                    w_credit_nxt = r_credit - ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_disp   <= '0;
            r_change <= 1'b0;
            r_rej    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_tick) begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_disp   <= w_disp_nxt;
            r_change <= w_change_nxt;
            r_rej    <= w_rej_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign disp     = r_disp;
    assign change   = r_change;
    assign coin_rej = r_rej;
    assign busy     = r_busy;
    assign credit   = r_credit;
    assign tick_out = nrst & w_tick;

endmodule

// File: tb/tb_vendo_param.sv
// Directed bench for vendo_param with DIV_COUNT=4 and the default price table (5,6,7,9).
module tb_vendo_param;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] sel;
    logic       p_1, p_5, cancel;
    logic [3:0] disp;
    logic       change, coin_rej, busy, tick_out;
    logic [4:0] credit;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;
    int per;

    vendo_param #(
        .N_ITEMS   (4),
        .PRICE_W   (4),
        .CREDIT_W  (5),
        .PRICE_LIST({4'd9, 4'd7, 4'd6, 4'd5}),
        .DIV_COUNT (4)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .sel     (sel),
        .p_1     (p_1),
        .p_5     (p_5),
        .cancel  (cancel),
        .disp    (disp),
        .change  (change),
        .coin_rej(coin_rej),
        .busy    (busy),
        .credit  (credit),
        .tick_out(tick_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // waits for the next tick edge and returns #1 after it
    task automatic do_tick();
        int found = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (tick_out === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (found == 0) chk("tick_found", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_period(output int p);
        int found = 0;
        p = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tick_out === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (found == 1) begin
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (tick_out === 1'b1) begin
                    p = n;
                    break;
                end
            end
        end
    endtask

    initial begin
        nrst = 1'b0; sel = 4'b0; p_1 = 1'b0; p_5 = 1'b0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp", disp, 0);
        chk("rst_change", change, 0);
        chk("rst_rej", coin_rej, 0);
        chk("rst_busy", busy, 0);
        chk("rst_credit", credit, 0);
        chk("rst_tick", tick_out, 0);
        @(negedge clk) nrst = 1'b1;
        measure_period(per);
        chk("tick_period", per, 4);

        // cancel with no credit does nothing
        cancel = 1'b1; do_tick(); cancel = 1'b0;
        chk("cancel0_busy", busy, 0);
        chk("cancel0_change", change, 0);

        // exact buy of item0 (price 5)
        p_5 = 1'b1; do_tick(); p_5 = 1'b0;
        chk("buy_credit5", credit, 5);
        sel = 4'b0001; do_tick(); sel = 4'b0;
        chk("buy_disp", disp, 4'b0001);
        chk("buy_credit0", credit, 0);
        chk("buy_busy", busy, 1);
        chk("buy_nochange", change, 0);
        @(negedge clk); @(negedge clk);
        chk("buy_disp_hold", disp, 4'b0001);
        do_tick();
        chk("buy_disp_end", disp, 0);
        chk("buy_idle_busy", busy, 0);
        chk("buy_idle_change", change, 0);

        // coin beats sel; then buy item3 (price 9) from 10, one change pulse
        p_5 = 1'b1; sel = 4'b0001; do_tick(); sel = 4'b0;
        chk("prio_coin_credit", credit, 5);
        chk("prio_coin_disp", disp, 0);
        do_tick(); p_5 = 1'b0;
        chk("chg_credit10", credit, 10);
        sel = 4'b1000; do_tick(); sel = 4'b0;
        chk("chg_disp", disp, 4'b1000);
        chk("chg_credit1", credit, 1);
        do_tick();
        chk("chg_disp_end", disp, 0);
        chk("chg_pulse", change, 1);
        chk("chg_credit0", credit, 0);
        chk("chg_busy", busy, 1);
        do_tick();
        chk("chg_low", change, 0);
        chk("chg_idle", busy, 0);

        // insufficient / invalid selections, then cancel refund of 3 with a busy coin
        p_1 = 1'b1; repeat (3) do_tick(); p_1 = 1'b0;
        chk("ins_credit3", credit, 3);
        sel = 4'b0100; do_tick();
        chk("ins_low_credit", credit, 3);
        chk("ins_low_disp", disp, 0);
        sel = 4'b0011; do_tick(); sel = 4'b0;
        chk("ins_multi_credit", credit, 3);
        chk("ins_multi_busy", busy, 0);
        cancel = 1'b1; do_tick(); cancel = 1'b0;
        chk("can_p1", change, 1);
        chk("can_cr2", credit, 2);
        chk("can_busy", busy, 1);
        do_tick();
        chk("can_l1", change, 0);
        p_5 = 1'b1; do_tick(); p_5 = 1'b0;
        chk("can_p2", change, 1);
        chk("bsy_rej", coin_rej, 1);
        chk("bsy_credit", credit, 1);
        chk("bsy_disp", disp, 0);
        chk("bsy_busy", busy, 1);
        do_tick();
        chk("can_l2", change, 0);
        chk("bsy_rej_end", coin_rej, 0);
        do_tick();
        chk("can_p3", change, 1);
        chk("can_cr0", credit, 0);
        do_tick();
        chk("can_l3", change, 0);
        chk("can_idle", busy, 0);

        // both coins = 6, fill to saturation, reject, then cancel+coin refunds 31
        p_1 = 1'b1; p_5 = 1'b1; do_tick(); p_1 = 1'b0;
        chk("both_coins", credit, 6);
        repeat (4) do_tick(); p_5 = 1'b0;
        p_1 = 1'b1; repeat (4) do_tick();
        chk("sat_credit30", credit, 30);
        do_tick();
        chk("sat_credit31", credit, 31);
        chk("sat_norej", coin_rej, 0);
        do_tick(); p_1 = 1'b0;
        chk("sat_rej", coin_rej, 1);
        chk("sat_hold31", credit, 31);
        cancel = 1'b1; p_5 = 1'b1; do_tick(); cancel = 1'b0; p_5 = 1'b0;
        chk("sat_can_credit", credit, 30);
        chk("sat_can_rej", coin_rej, 0);
        chk("sat_can_pulse", change, 1);
        pulses = 1;
        for (int i = 0; i < 70 && busy === 1'b1; i++) begin
            do_tick();
            if (change === 1'b1) pulses++;
        end
        chk("sat_pulses", pulses, 31);
        chk("sat_end_busy", busy, 0);
        chk("sat_end_credit", credit, 0);

        // reset in the middle of CHANGE with credit 3
        p_1 = 1'b1; repeat (4) do_tick(); p_1 = 1'b0;
        cancel = 1'b1; do_tick(); cancel = 1'b0;
        chk("mid_credit3", credit, 3);
        chk("mid_busy", busy, 1);
        @(negedge clk) nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_disp", disp, 0);
        chk("mrst_change", change, 0);
        chk("mrst_rej", coin_rej, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_credit", credit, 0);
        chk("mrst_tick", tick_out, 0);
        @(negedge clk) nrst = 1'b1;
        measure_period(per);
        chk("mrst_period", per, 4);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            chk("mrst_nochange", change, 0);
        end
        chk("mrst_credit_end", credit, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
